// File: rtl/ahb_arbiter_pkg.sv
// rtl/ahb_arbiter_pkg.sv - shared AHB-lite types for the two-master arbiter
// Purpose: transfer-type and owner enums, the address-phase struct, and
//          a helper that tells whether a transfer keeps the grant locked.
// Ports:   none (package).
package ahb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef struct packed {
        htrans_t     htrans;
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
    } ahb_addr_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        M0   = 2'b01,
        M1   = 2'b10
    } ahb_owner_t;

    localparam ahb_addr_t AHB_ADDR_IDLE = '{htrans: IDLE, haddr: 32'h0, hwrite: 1'b0, hsize: 3'b000};

    // A burst in progress (SEQ/BUSY) must not lose the bus mid-way.
    function automatic logic htrans_locks(input htrans_t t);
        return (t == SEQ) || (t == BUSY);
    endfunction

endpackage

// File: rtl/ahb_arbiter_port.sv
// rtl/ahb_arbiter_port.sv - one master side: pend register, capture, hready/hresp
// Purpose: accepts the master's address phase, forwarding it when it owns the
//          bus or parking it in a one-entry pend register for later replay.
// Ports:   i_clk, i_nrst            clock, async active-low reset
//          i_htrans..i_hsize        master address phase
//          i_granted, i_owner       this side holds the grant / the data phase
//          i_bus_hready, i_bus_hresp bus response
//          o_hready, o_hresp        master response
//          o_req, o_addr            arbitration request, address phase offered to the bus
module ahb_arbiter_port
    import ahb_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [1:0]  i_htrans,
    input  logic [31:0] i_haddr,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic        i_granted,
    input  logic        i_owner,
    input  logic        i_bus_hready,
    input  logic        i_bus_hresp,
    output logic        o_hready,
    output logic        o_hresp,
    output logic        o_req,
    output ahb_addr_t   o_addr
);

    ahb_addr_t r_pend;
    logic      r_pend_valid;
    ahb_addr_t w_live;
    logic      w_accept;
    logic      w_direct;
    logic      w_replay;

    assign w_live = '{htrans: htrans_t'(i_htrans), haddr: i_haddr, hwrite: i_hwrite, hsize: i_hsize};

    // A valid pend entry holds hready low, so a second capture cannot overwrite it.
    assign o_hready = i_owner ? i_bus_hready : ~r_pend_valid;
    assign o_hresp  = i_owner & i_bus_hresp;
    assign o_req    = r_pend_valid | i_htrans[1];
    assign o_addr   = r_pend_valid ? r_pend : w_live;

    assign w_accept = o_hready & i_htrans[1];
    assign w_direct = i_granted & ~r_pend_valid & i_bus_hready;
    assign w_replay = i_granted & r_pend_valid & i_bus_hready;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_pend_valid <= 1'b0;
            r_pend       <= AHB_ADDR_IDLE;
        end else if (w_accept && !w_direct) begin
            r_pend_valid <= 1'b1;
            r_pend       <= w_live;
        end else if (w_replay) begin
            r_pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - two-master AHB-lite arbiter, fixed priority with M1 anti-starvation
// Purpose: shares one AHB-lite bus between M0 (CPU) and M1; M0 wins ties unless
//          M1 has lost MAX_WAIT arbitrations in a row.
// Ports:   i_clk, i_nrst                         clock, async active-low reset
//          i_m0_* / o_m0_*                       M0 address phase, hwdata in; hrdata/hready/hresp out
//          i_m1_* / o_m1_*                       M1, same set
//          o_bus_* / i_bus_*                     to the bus: address phase, hwdata out; hrdata/hready/hresp in
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [1:0]  i_m0_htrans,
    input  logic [31:0] i_m0_haddr,
    input  logic        i_m0_hwrite,
    input  logic [2:0]  i_m0_hsize,
    input  logic [31:0] i_m0_hwdata,
    output logic [31:0] o_m0_hrdata,
    output logic        o_m0_hready,
    output logic        o_m0_hresp,
    input  logic [1:0]  i_m1_htrans,
    input  logic [31:0] i_m1_haddr,
    input  logic        i_m1_hwrite,
    input  logic [2:0]  i_m1_hsize,
    input  logic [31:0] i_m1_hwdata,
    output logic [31:0] o_m1_hrdata,
    output logic        o_m1_hready,
    output logic        o_m1_hresp,
    output logic [1:0]  o_bus_htrans,
    output logic [31:0] o_bus_haddr,
    output logic        o_bus_hwrite,
    output logic [2:0]  o_bus_hsize,
    output logic [31:0] o_bus_hwdata,
    input  logic [31:0] i_bus_hrdata,
    input  logic        i_bus_hready,
    input  logic        i_bus_hresp
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    ahb_owner_t  r_gnt;
    ahb_owner_t  r_data_owner;
    logic [WW-1:0] r_wait_cnt;

    ahb_addr_t   w_m0_addr;
    ahb_addr_t   w_m1_addr;
    ahb_addr_t   w_bus_addr;
    logic        w_m0_req;
    logic        w_m1_req;
    logic        w_lock;
    ahb_owner_t  w_next_gnt;

    ahb_arbiter_port u_port_m0 (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_htrans     (i_m0_htrans),
        .i_haddr      (i_m0_haddr),
        .i_hwrite     (i_m0_hwrite),
        .i_hsize      (i_m0_hsize),
        .i_granted    (r_gnt == M0),
        .i_owner      (r_data_owner == M0),
        .i_bus_hready (i_bus_hready),
        .i_bus_hresp  (i_bus_hresp),
        .o_hready     (o_m0_hready),
        .o_hresp      (o_m0_hresp),
        .o_req        (w_m0_req),
        .o_addr       (w_m0_addr)
    );

    ahb_arbiter_port u_port_m1 (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_htrans     (i_m1_htrans),
        .i_haddr      (i_m1_haddr),
        .i_hwrite     (i_m1_hwrite),
        .i_hsize      (i_m1_hsize),
        .i_granted    (r_gnt == M1),
        .i_owner      (r_data_owner == M1),
        .i_bus_hready (i_bus_hready),
        .i_bus_hresp  (i_bus_hresp),
        .o_hready     (o_m1_hready),
        .o_hresp      (o_m1_hresp),
        .o_req        (w_m1_req),
        .o_addr       (w_m1_addr)
    );

    assign o_m0_hrdata = i_bus_hrdata;
    assign o_m1_hrdata = i_bus_hrdata;

    // Only the granted side ever drives the bus address phase.
    assign w_bus_addr   = (r_gnt == M1) ? w_m1_addr : w_m0_addr;
    assign o_bus_htrans = i_nrst ? w_bus_addr.htrans : IDLE;
    assign o_bus_haddr  = w_bus_addr.haddr;
    assign o_bus_hwrite = w_bus_addr.hwrite;
    assign o_bus_hsize  = w_bus_addr.hsize;

    always_comb begin
        o_bus_hwdata = 32'h0;
        case (r_data_owner)
            M0:      o_bus_hwdata = i_m0_hwdata;
            M1:      o_bus_hwdata = i_m1_hwdata;
            default: o_bus_hwdata = 32'h0;
        endcase
    end

    assign w_lock = htrans_locks(w_bus_addr.htrans);

    always_comb begin
        w_next_gnt = r_gnt;
        if (!w_lock) begin
            if (w_m0_req && w_m1_req) begin
                w_next_gnt = (r_wait_cnt == WW'(MAX_WAIT)) ? M1 : M0;
            end else if (w_m0_req) begin
                w_next_gnt = M0;
            end else if (w_m1_req) begin
                w_next_gnt = M1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_gnt        <= M0;
            r_data_owner <= NONE;
            r_wait_cnt   <= '0;
        end else if (i_bus_hready) begin
            r_gnt        <= w_next_gnt;
            r_data_owner <= w_bus_addr.htrans[1] ? r_gnt : NONE;
            if (w_next_gnt == M1) begin
                r_wait_cnt <= '0;
            end else if (!w_lock && w_m1_req && (r_wait_cnt != WW'(MAX_WAIT))) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter
module tb_ahb_arbiter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [1:0]  m0_htrans = 2'b00, m1_htrans = 2'b00;
    logic [31:0] m0_haddr = 32'h0, m1_haddr = 32'h0;
    logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
    logic [2:0]  m0_hsize = 3'b010, m1_hsize = 3'b010;
    logic [31:0] m0_hwdata = 32'h0, m1_hwdata = 32'h0;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [1:0]  bus_htrans;
    logic [31:0] bus_haddr, bus_hwdata, bus_hrdata;
    logic        bus_hwrite;
    logic [2:0]  bus_hsize;
    logic        bus_hready, bus_hresp;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ahb_arbiter #(.MAX_WAIT(8)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_m0_htrans  (m0_htrans),
        .i_m0_haddr   (m0_haddr),
        .i_m0_hwrite  (m0_hwrite),
        .i_m0_hsize   (m0_hsize),
        .i_m0_hwdata  (m0_hwdata),
        .o_m0_hrdata  (m0_hrdata),
        .o_m0_hready  (m0_hready),
        .o_m0_hresp   (m0_hresp),
        .i_m1_htrans  (m1_htrans),
        .i_m1_haddr   (m1_haddr),
        .i_m1_hwrite  (m1_hwrite),
        .i_m1_hsize   (m1_hsize),
        .i_m1_hwdata  (m1_hwdata),
        .o_m1_hrdata  (m1_hrdata),
        .o_m1_hready  (m1_hready),
        .o_m1_hresp   (m1_hresp),
        .o_bus_htrans (bus_htrans),
        .o_bus_haddr  (bus_haddr),
        .o_bus_hwrite (bus_hwrite),
        .o_bus_hsize  (bus_hsize),
        .o_bus_hwdata (bus_hwdata),
        .i_bus_hrdata (bus_hrdata),
        .i_bus_hready (bus_hready),
        .i_bus_hresp  (bus_hresp)
    );

    // Zero-wait slave with 16 words; addresses 0xF....... answer with a two-cycle ERROR.
    logic [31:0] mem [16];
    logic        dp_valid, dp_write, dp_err, err_phase;
    logic [31:0] dp_addr;

    always_comb begin
        bus_hready = 1'b1;
        bus_hresp  = 1'b0;
        if (dp_valid && dp_err) begin
            bus_hresp  = 1'b1;
            bus_hready = err_phase;
        end
        bus_hrdata = dp_valid ? mem[dp_addr[5:2]] : 32'h0;
    end

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_err    <= 1'b0;
            dp_addr   <= 32'h0;
            err_phase <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (bus_hready) begin
            if (dp_valid && dp_write && !dp_err) mem[dp_addr[5:2]] <= bus_hwdata;
            dp_valid  <= bus_htrans[1];
            dp_write  <= bus_hwrite;
            dp_addr   <= bus_haddr;
            dp_err    <= (bus_haddr[31:28] == 4'hF);
            err_phase <= 1'b0;
        end else begin
            err_phase <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_m0(input logic [1:0] t, input logic [31:0] a, input logic w);
        m0_htrans = t; m0_haddr = a; m0_hwrite = w;
    endtask

    task automatic drv_m1(input logic [1:0] t, input logic [31:0] a, input logic w);
        m1_htrans = t; m1_haddr = a; m1_hwrite = w;
    endtask

    initial begin
        // reset state, live M0 request must not reach the bus
        #2;
        drv_m0(2'b10, 32'h4, 1'b0);
        m0_hwdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_hready_m0", 32'(m0_hready), 32'd1);
        chk("rst_hready_m1", 32'(m1_hready), 32'd1);
        chk("rst_hresp_m0", 32'(m0_hresp), 32'd0);
        chk("rst_hresp_m1", 32'(m1_hresp), 32'd0);
        chk("rst_bus_htrans", 32'(bus_htrans), 32'd0);
        chk("rst_bus_hwdata", bus_hwdata, 32'h0);
        drv_m0(2'b00, 32'h0, 1'b0);
        m0_hwdata = 32'h0;
        step();
        step();
        nrst = 1'b1;

        // T1: M0 write then read of 0x4, no added latency
        drv_m0(2'b10, 32'h4, 1'b1);
        #1;
        chk("t1_wr_htrans", 32'(bus_htrans), 32'd2);
        chk("t1_wr_haddr", bus_haddr, 32'h4);
        chk("t1_wr_hwrite", 32'(bus_hwrite), 32'd1);
        step();
        drv_m0(2'b10, 32'h4, 1'b0);
        m0_hwdata = 32'h0123_4567;
        #1;
        chk("t1_rd_haddr", bus_haddr, 32'h4);
        chk("t1_rd_hwrite", 32'(bus_hwrite), 32'd0);
        chk("t1_hwdata", bus_hwdata, 32'h0123_4567);
        chk("t1_hready_m0", 32'(m0_hready), 32'd1);
        step();
        drv_m0(2'b00, 32'h0, 1'b0);
        m0_hwdata = 32'h0;
        #1;
        chk("t1_hrdata_m0", m0_hrdata, 32'h0123_4567);
        chk("t1_rd_hready_m0", 32'(m0_hready), 32'd1);
        step();

        // T2: M1 alone reads 0x8 with grant parked on M0
        drv_m1(2'b10, 32'h8, 1'b0);
        #1;
        chk("t2_hready_m1_req", 32'(m1_hready), 32'd1);
        chk("t2_bus_idle", 32'(bus_htrans), 32'd0);
        step();
        drv_m1(2'b00, 32'h0, 1'b0);
        #1;
        chk("t2_hready_m1_pend", 32'(m1_hready), 32'd0);
        chk("t2_bus_htrans", 32'(bus_htrans), 32'd2);
        chk("t2_bus_haddr", bus_haddr, 32'h8);
        step();
        #1;
        chk("t2_hready_m1_data", 32'(m1_hready), 32'd1);
        chk("t2_hrdata_m1", m1_hrdata, 32'hA000_0002);
        step();

        // re-park grant on M0 via a pended M0 read of 0xC
        drv_m0(2'b10, 32'hC, 1'b0);
        #1;
        chk("pk_bus_idle", 32'(bus_htrans), 32'd0);
        step();
        drv_m0(2'b00, 32'h0, 1'b0);
        #1;
        chk("pk_hready_m0_pend", 32'(m0_hready), 32'd0);
        chk("pk_bus_haddr", bus_haddr, 32'hC);
        step();
        #1;
        chk("pk_hrdata_m0", m0_hrdata, 32'hA000_0003);
        step();

        // T3: simultaneous NONSEQ, M0 first then M1
        drv_m0(2'b10, 32'h0, 1'b0);
        drv_m1(2'b10, 32'h10, 1'b0);
        #1;
        chk("t3_bus_haddr_m0", bus_haddr, 32'h0);
        chk("t3_hready_m1", 32'(m1_hready), 32'd1);
        step();
        drv_m0(2'b00, 32'h0, 1'b0);
        drv_m1(2'b00, 32'h0, 1'b0);
        #1;
        chk("t3_hrdata_m0", m0_hrdata, 32'hA000_0000);
        chk("t3_hready_m1_pend", 32'(m1_hready), 32'd0);
        step();
        #1;
        chk("t3_bus_htrans_m1", 32'(bus_htrans), 32'd2);
        chk("t3_bus_haddr_m1", bus_haddr, 32'h10);
        chk("t3_gnt_m1", 32'(dut.r_gnt), 32'd2);
        step();
        #1;
        chk("t3_hready_m1_data", 32'(m1_hready), 32'd1);
        chk("t3_hrdata_m1", m1_hrdata, 32'hA000_0004);
        step();

        // T4: M0 back-to-back reads starve M1 for exactly 8 arbitrations
        drv_m0(2'b10, 32'h0, 1'b0);
        step();
        drv_m1(2'b10, 32'h14, 1'b0);
        #1;
        chk("t4_hready_m0_pend", 32'(m0_hready), 32'd0);
        step();
        drv_m1(2'b00, 32'h0, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            #1;
            chk("t4_wait_cnt", 32'(dut.r_wait_cnt), 32'(k - 1));
            chk("t4_bus_haddr_m0", bus_haddr, 32'h0);
            chk("t4_hready_m1", 32'(m1_hready), 32'd0);
            step();
        end
        #1;
        chk("t4_bus_haddr_m1", bus_haddr, 32'h14);
        chk("t4_gnt_m1", 32'(dut.r_gnt), 32'd2);
        chk("t4_wait_clear", 32'(dut.r_wait_cnt), 32'd0);
        step();
        drv_m0(2'b00, 32'h0, 1'b0);
        #1;
        chk("t4_hrdata_m1", m1_hrdata, 32'hA000_0005);
        chk("t4_hready_m1_data", 32'(m1_hready), 32'd1);
        chk("t4_bus_haddr_m0_pend", bus_haddr, 32'h0);
        step();
        #1;
        chk("t4_hready_m0_data", 32'(m0_hready), 32'd1);
        step();

        // T5: contended M1 read of unmapped 0xF0000000 gets ERROR
        drv_m0(2'b10, 32'h0, 1'b0);
        drv_m1(2'b10, 32'hF000_0000, 1'b0);
        #1;
        chk("t5_bus_haddr_m0", bus_haddr, 32'h0);
        step();
        drv_m0(2'b00, 32'h0, 1'b0);
        drv_m1(2'b00, 32'h0, 1'b0);
        step();
        #1;
        chk("t5_bus_haddr_m1", bus_haddr, 32'hF000_0000);
        step();
        #1;
        chk("t5_err1_hresp_m1", 32'(m1_hresp), 32'd1);
        chk("t5_err1_hready_m1", 32'(m1_hready), 32'd0);
        chk("t5_err1_hresp_m0", 32'(m0_hresp), 32'd0);
        step();
        #1;
        chk("t5_err2_hresp_m1", 32'(m1_hresp), 32'd1);
        chk("t5_err2_hready_m1", 32'(m1_hready), 32'd1);
        chk("t5_err2_hresp_m0", 32'(m0_hresp), 32'd0);
        step();
        #1;
        chk("t5_after_hresp_m1", 32'(m1_hresp), 32'd0);
        step();

        // T6: reset while pend_m1 valid and an M0 transfer is in flight
        drv_m0(2'b10, 32'h4, 1'b0);
        drv_m1(2'b10, 32'h8, 1'b0);
        #1;
        chk("t6_bus_haddr_m1", bus_haddr, 32'h8);
        step();
        drv_m0(2'b00, 32'h0, 1'b0);
        drv_m1(2'b10, 32'hC, 1'b0);
        #1;
        chk("t6_bus_haddr_pend0", bus_haddr, 32'h4);
        chk("t6_hrdata_m1", m1_hrdata, 32'hA000_0002);
        step();
        drv_m0(2'b10, 32'h0, 1'b0);
        drv_m1(2'b00, 32'h0, 1'b0);
        m0_hwdata = 32'h0000_0055;
        #1;
        chk("t6_pend_m1_hready", 32'(m1_hready), 32'd0);
        chk("t6_hwdata_m0", bus_hwdata, 32'h0000_0055);
        nrst = 1'b0;
        #1;
        chk("t6_rst_hready_m0", 32'(m0_hready), 32'd1);
        chk("t6_rst_hready_m1", 32'(m1_hready), 32'd1);
        chk("t6_rst_hresp_m1", 32'(m1_hresp), 32'd0);
        chk("t6_rst_bus_htrans", 32'(bus_htrans), 32'd0);
        chk("t6_rst_bus_hwdata", bus_hwdata, 32'h0);
        chk("t6_rst_gnt", 32'(dut.r_gnt), 32'd1);
        drv_m0(2'b00, 32'h0, 1'b0);
        m0_hwdata = 32'h0;
        step();
        step();
        nrst = 1'b1;
        drv_m0(2'b10, 32'h4, 1'b0);
        #1;
        chk("t6_post_bus_haddr", bus_haddr, 32'h4);
        step();
        drv_m0(2'b00, 32'h0, 1'b0);
        #1;
        chk("t6_post_hrdata_m0", m0_hrdata, 32'hA000_0001);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
